multi_pueo_beam_thresh: RTL and testbench



---
 rtl/multi_pueo_beam_thresh.sv | 131 +++++++++++++
 tb/tb_multi_pueo_beam_thresh.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multi_pueo_beam_thresh.sv
// Per-beam boxcar threshold trigger: two-input sum, NTAPS-deep running window,
// strict compare against double-buffered thresholds, and per-beam holdoff.
module multi_pueo_beam_thresh #(
    parameter int NBEAMS     = 2,
    parameter int INBITS     = 17,
    parameter int NTAPS      = 2,
    parameter int THRESHBITS = 20,
    parameter int HOLDOFF    = 4,
    localparam int ADDRBITS  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NBEAMS*INBITS-1:0] beam_in0_i,
    input  logic [NBEAMS*INBITS-1:0] beam_in1_i,
    input  logic [THRESHBITS-1:0]    thresh_i,
    input  logic [ADDRBITS-1:0]      thresh_addr_i,
    input  logic                     thresh_wr_i,
    input  logic                     update_i,
    output logic [NBEAMS-1:0]        trigger_o
);

    localparam int TBITS   = INBITS + 1;
    localparam int SUMBITS = INBITS + 1 + $clog2(NTAPS);
    localparam int HISTD   = (NTAPS > 1) ? NTAPS - 1 : 1;

    generate
        if (THRESHBITS < SUMBITS) begin : g_bad_thresh_width
            $error("THRESHBITS must be at least INBITS+1+clog2(NTAPS)");
        end
    endgenerate

    logic [TBITS-1:0]      t_q      [NBEAMS];
    logic [TBITS-1:0]      t_d      [NBEAMS];
    logic [TBITS-1:0]      hist_q   [NBEAMS][HISTD];
    logic [TBITS-1:0]      hist_d   [NBEAMS][HISTD];
    logic [SUMBITS-1:0]    s_q      [NBEAMS];
    logic [SUMBITS-1:0]    s_d      [NBEAMS];
    logic [THRESHBITS-1:0] shadow_q [NBEAMS];
    logic [THRESHBITS-1:0] shadow_d [NBEAMS];
    logic [THRESHBITS-1:0] active_q [NBEAMS];
    logic [THRESHBITS-1:0] active_d [NBEAMS];
    logic [NBEAMS-1:0]     raw_q;
    logic [NBEAMS-1:0]     raw_d;
    logic [NBEAMS-1:0]     trig_q;
    logic [NBEAMS-1:0]     trig_d;
    logic [SUMBITS-1:0]    acc;

    // hist holds the NTAPS-1 samples preceding t_q, newest at index 0.
    always_comb begin
        acc = '0;
        for (int n = 0; n < NBEAMS; n++) begin
            t_d[n] = TBITS'(beam_in0_i[n*INBITS +: INBITS])
                   + TBITS'(beam_in1_i[n*INBITS +: INBITS]);
            acc = SUMBITS'(t_q[n]);
            for (int i = 0; i < NTAPS - 1; i++) begin
                acc = acc + SUMBITS'(hist_q[n][i]);
            end
            s_d[n] = acc;
            hist_d[n][0] = t_q[n];
            for (int i = 1; i < HISTD; i++) begin
                hist_d[n][i] = hist_q[n][i-1];
            end
            raw_d[n] = THRESHBITS'(s_q[n]) > active_q[n];
        end
    end

    // Update copies the pre-write shadow, so a same-cycle write waits for the next update.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (update_i) begin
            active_d = shadow_q;
        end
        if (thresh_wr_i && (int'(thresh_addr_i) < NBEAMS)) begin
            shadow_d[thresh_addr_i] = thresh_i;
        end
    end

    generate
        if (HOLDOFF > 0) begin : g_holdoff
            logic [7:0] cnt_q [NBEAMS];
            logic [7:0] cnt_d [NBEAMS];

            always_comb begin
                trig_d = '0;
                for (int n = 0; n < NBEAMS; n++) begin
                    cnt_d[n] = cnt_q[n];
                    if (cnt_q[n] != 8'd0) begin
                        cnt_d[n] = cnt_q[n] - 8'd1;
                    end else if (raw_q[n]) begin
                        trig_d[n] = 1'b1;
                        cnt_d[n]  = 8'(HOLDOFF);
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cnt_q <= '{default: '0};
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_holdoff
            assign trig_d = raw_q;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q      <= '{default: '0};
            hist_q   <= '{default: '{default: '0}};
            s_q      <= '{default: '0};
            raw_q    <= '0;
            trig_q   <= '0;
            shadow_q <= '{default: '1};
            active_q <= '{default: '1};
        end else begin
            t_q      <= t_d;
            hist_q   <= hist_d;
            s_q      <= s_d;
            raw_q    <= raw_d;
            trig_q   <= trig_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign trigger_o = trig_q;

endmodule

// File: tb/tb_multi_pueo_beam_thresh.sv
// Directed bench for multi_pueo_beam_thresh at default parameters; expected
// trigger patterns are hand-derived from the 3-edge latency and 5-cycle holdoff period.
module tb_multi_pueo_beam_thresh;

    localparam int NB = 2;
    localparam int IB = 17;
    localparam int TW = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB*IB-1:0]  in0 = '0;
    logic [NB*IB-1:0]  in1 = '0;
    logic [TW-1:0]     thresh = '0;
    logic [0:0]        addr = '0;
    logic              wr = 1'b0;
    logic              upd = 1'b0;
    logic [NB-1:0]     trig;

    int n_checks = 0;
    int n_pass   = 0;

    multi_pueo_beam_thresh dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .beam_in0_i    (in0),
        .beam_in1_i    (in1),
        .thresh_i      (thresh),
        .thresh_addr_i (addr),
        .thresh_wr_i   (wr),
        .update_i      (upd),
        .trigger_o     (trig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_beam(input int b, input logic [IB-1:0] a, input logic [IB-1:0] c);
        in0[b*IB +: IB] = a;
        in1[b*IB +: IB] = c;
    endtask

    task automatic write_thresh(input int b, input logic [TW-1:0] v, input logic with_upd);
        wr     = 1'b1;
        addr   = 1'(b);
        thresh = v;
        upd    = with_upd;
        tick();
        wr     = 1'b0;
        upd    = 1'b0;
    endtask

    initial begin
        // Reset behaviour, including asynchronous clear before any clock edge
        #1;
        rst_n = 1'b0;
        #2;
        chk("reset_async_start", trig, 2'b00);
        tick();
        tick();
        chk("reset_held", trig, 2'b00);
        rst_n = 1'b1;

        // Full-scale inputs never exceed the all-ones reset threshold
        set_beam(0, 17'h1FFFF, 17'h1FFFF);
        set_beam(1, 17'h1FFFF, 17'h1FFFF);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fullscale_no_trig", trig, 2'b00);
        end

        // Beam0 threshold 80000, steady S = 80000 is not strictly above it
        set_beam(0, 17'd20000, 17'd20000);
        set_beam(1, 17'd20000, 17'd20000);
        repeat (4) tick();
        write_thresh(0, 20'd80000, 1'b0);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("steady_equal_no_trig", trig, 2'b00);
        end

        // One-cycle excursion: single pulse on beam0 three edges after sampling
        set_beam(0, 17'd20001, 17'd20000);
        tick();
        chk("pulse_edge_k", trig, 2'b00);
        set_beam(0, 17'd20000, 17'd20000);
        tick();
        chk("pulse_edge_k1", trig, 2'b00);
        tick();
        chk("pulse_edge_k2", trig, 2'b00);
        tick();
        chk("pulse_edge_k3", trig, 2'b01);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pulse_single", trig, 2'b00);
        end

        // Beam1 shadow write alone has no effect until update
        write_thresh(1, 20'd100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("shadow_only_no_effect", trig, 2'b00);
        end
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("update_edge_u", trig, 2'b00);
        tick();
        chk("update_edge_u1", trig, 2'b00);
        tick();
        chk("update_first_fire", trig, 2'b10);
        // Above-threshold held: re-fire every HOLDOFF+1 = 5 cycles
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("holdoff_period", trig, (i % 5 == 0) ? 2'b10 : 2'b00);
        end

        // Same-cycle write+update: active keeps 80000 for beam0
        write_thresh(0, 20'd50, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wr_upd_same_cycle_old", {1'b0, trig[0]}, 2'b00);
        end
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("late_update_u", {1'b0, trig[0]}, 2'b00);
        tick();
        chk("late_update_u1", {1'b0, trig[0]}, 2'b00);
        tick();
        chk("late_update_fire", {1'b0, trig[0]}, 2'b01);
        tick();
        tick();

        // Reset two cycles into holdoff
        rst_n = 1'b0;
        #1;
        chk("reset_mid_holdoff_async", trig, 2'b00);
        tick();
        chk("reset_mid_holdoff_held", trig, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_reset_thresh_ones", trig, 2'b00);
        end

        // Rewrite beam0 only; beam1 shadow/active are all ones again
        write_thresh(0, 20'd50, 1'b0);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        chk("rearm_u", trig, 2'b00);
        tick();
        chk("rearm_u1", trig, 2'b00);
        tick();
        chk("rearm_fire_beam0_only", trig, 2'b01);
        tick();
        chk("rearm_holdoff", trig, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
